// File: rtl/lock_scheduler.sv
// lock_scheduler: two-gate canal lock sequencer; arbitrates upper/lower boat requests and drives valves and gates
//   clk, reset (async, active-low)
//   req_upper/req_lower : request pulses; boat_in/boat_out : occupancy sensor pulses
//   water_level         : chamber level, unsigned
//   upper_gate/lower_gate/fill/drain : registered actuator commands
//   occupied, pend_upper, pend_lower, busy : registered status
module lock_scheduler #(
    parameter int LEVEL_W       = 6,
    parameter int HIGH_LEVEL    = 50,
    parameter int LOW_LEVEL     = 10,
    parameter int GATE_CYCLES   = 4,
    parameter int ENTRY_TIMEOUT = 63
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_upper,
    input  logic               req_lower,
    input  logic               boat_in,
    input  logic               boat_out,
    input  logic [LEVEL_W-1:0] water_level,
    output logic               upper_gate,
    output logic               lower_gate,
    output logic               fill,
    output logic               drain,
    output logic               occupied,
    output logic               pend_upper,
    output logic               pend_lower,
    output logic               busy
);
    localparam int MAX_CNT = ENTRY_TIMEOUT > GATE_CYCLES ? ENTRY_TIMEOUT : GATE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [LEVEL_W-1:0] HIGH_L    = LEVEL_W'(HIGH_LEVEL);
    localparam logic [LEVEL_W-1:0] LOW_L     = LEVEL_W'(LOW_LEVEL);
    localparam logic [CNT_W-1:0]   GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(ENTRY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_TOP   = CNT_W'(MAX_CNT);

    typedef enum logic [3:0] {
        IDLE, ADJUST_IN, OPEN_IN, WAIT_IN, CLOSE_IN, TRANSFER, OPEN_OUT, WAIT_OUT, CLOSE_OUT
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             dir, last_served;  // 1 = upper side
    logic             grant, win_upper, adj_upper, met, gate_done, adjusting;
    logic             ent_open, exit_open, occ_n;

    always_comb begin
        grant     = (state == IDLE) && (pend_upper || pend_lower);
        // a tie goes to the side that was not served last
        win_upper = pend_upper && (!pend_lower || !last_served);
        // entry equalizes toward dir, transfer toward the opposite side
        adj_upper = (state == ADJUST_IN) ? dir : !dir;
        met       = adj_upper ? (water_level >= HIGH_L) : (water_level <= LOW_L);
        gate_done = cnt == GATE_LAST;
        adjusting = (state == ADJUST_IN) || (state == TRANSFER);
        state_n   = state;
        occ_n     = occupied;
        case (state)
            IDLE:      state_n = grant ? ADJUST_IN : IDLE;
            ADJUST_IN: state_n = met ? OPEN_IN : ADJUST_IN;
            OPEN_IN:   state_n = gate_done ? WAIT_IN : OPEN_IN;
            WAIT_IN: begin
                occ_n   = occupied || boat_in;
                state_n = (boat_in || cnt == TO_LAST) ? CLOSE_IN : WAIT_IN;
            end
            CLOSE_IN:  state_n = gate_done ? (occupied ? TRANSFER : IDLE) : CLOSE_IN;
            TRANSFER:  state_n = met ? OPEN_OUT : TRANSFER;
            OPEN_OUT:  state_n = gate_done ? WAIT_OUT : OPEN_OUT;
            WAIT_OUT: begin
                occ_n   = occupied && !boat_out;
                state_n = boat_out ? CLOSE_OUT : WAIT_OUT;
            end
            CLOSE_OUT: state_n = gate_done ? IDLE : CLOSE_OUT;
            default:   state_n = IDLE;
        endcase
        ent_open  = (state_n == OPEN_IN) || (state_n == WAIT_IN);
        exit_open = (state_n == OPEN_OUT) || (state_n == WAIT_OUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            dir         <= 1'b0;
            last_served <= 1'b0;
            upper_gate  <= 1'b0;
            lower_gate  <= 1'b0;
            fill        <= 1'b0;
            drain       <= 1'b0;
            occupied    <= 1'b0;
            pend_upper  <= 1'b0;
            pend_lower  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= (state_n != state) ? '0 : (cnt == CNT_TOP ? cnt : cnt + 1'b1);
            dir         <= grant ? win_upper : dir;
            last_served <= grant ? win_upper : last_served;
            // a new pulse on the grant edge re-arms the request
            pend_upper  <= req_upper || (pend_upper && !(grant && win_upper));
            pend_lower  <= req_lower || (pend_lower && !(grant && !win_upper));
            occupied    <= occ_n;
            fill        <= adjusting && !met && adj_upper;
            drain       <= adjusting && !met && !adj_upper;
            upper_gate  <= (ent_open && dir) || (exit_open && !dir);
            lower_gate  <= (ent_open && !dir) || (exit_open && dir);
            busy        <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_lock_scheduler.sv
// tb_lock_scheduler: self-checking bench for lock_scheduler with a simple chamber water model
module tb_lock_scheduler;
    logic       clk = 0, reset = 0;
    logic       req_upper = 0, req_lower = 0, boat_in = 0, boat_out = 0;
    logic [5:0] water_level = 0;
    logic       upper_gate, lower_gate, fill, drain, occupied, pend_upper, pend_lower, busy;
    logic [7:0] outs;
    int         checks = 0, errors = 0;
    bit         exp_q[$];  // expected entry side per grant, 1 = upper

    assign outs = {upper_gate, lower_gate, fill, drain, occupied, pend_upper, pend_lower, busy};

    always #5 clk = ~clk;

    lock_scheduler dut (
        .clk(clk), .reset(reset), .req_upper(req_upper), .req_lower(req_lower),
        .boat_in(boat_in), .boat_out(boat_out), .water_level(water_level),
        .upper_gate(upper_gate), .lower_gate(lower_gate), .fill(fill), .drain(drain),
        .occupied(occupied), .pend_upper(pend_upper), .pend_lower(pend_lower), .busy(busy)
    );

    // one clock; the chamber level follows the valves seen before the edge
    task automatic cyc();
        logic f, d;
        f = fill;
        d = drain;
        @(posedge clk);
        #1;
        if (f && water_level != 6'd63) water_level = water_level + 6'd1;
        if (d && water_level != 6'd0) water_level = water_level - 6'd1;
    endtask

    task automatic do_reset();
        reset = 0;
        {req_upper, req_lower, boat_in, boat_out} = '0;
        exp_q.delete();
        cyc();
        cyc();
        reset = 1;
        cyc();
    endtask

    task automatic pulse(input bit up, input bit lo, input bit bin, input bit bout);
        req_upper = up;
        req_lower = lo;
        boat_in   = bin;
        boat_out  = bout;
        cyc();
        {req_upper, req_lower, boat_in, boat_out} = '0;
    endtask

    task automatic wait_gate(input string name, output bit side, output bit saw_fill, output bit saw_drain);
        int n = 0;
        saw_fill  = 0;
        saw_drain = 0;
        while (!(upper_gate || lower_gate) && n < 300) begin
            saw_fill  |= fill;
            saw_drain |= drain;
            cyc();
            n++;
        end
        checks++;
        if (!(upper_gate || lower_gate)) begin
            errors++;
            $display("FAIL %s: no gate opened within %0d cycles", name, n);
        end
        side = upper_gate;
    endtask

    task automatic check_entry(input string name, output bit saw_fill, output bit saw_drain);
        bit side, exp;
        wait_gate(name, side, saw_fill, saw_drain);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: entry gate opened with no grant expected", name);
        end else begin
            exp = exp_q.pop_front();
            if (side !== exp) begin
                errors++;
                $display("FAIL %s: entry side got %0b expected %0b", name, side, exp);
            end
        end
    endtask

    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (busy && n < 300) begin
            cyc();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: busy still 1 after %0d cycles", name, n);
        end
    endtask

    task automatic test_reset();
        reset = 0;
        cyc();
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000", outs);
        end
        reset = 1;
        cyc();
    endtask

    task automatic test_upper_transit();
        bit sf, sd, side;
        int n;
        do_reset();
        water_level = 10;
        pulse(1, 0, 0, 0);
        exp_q.push_back(1);
        checks++;
        if ({pend_upper, busy} !== 2'b10) begin
            errors++;
            $display("FAIL latch_upper: pend_upper,busy got %b expected 10", {pend_upper, busy});
        end
        cyc();
        checks++;
        if ({pend_upper, busy} !== 2'b01) begin
            errors++;
            $display("FAIL grant_upper: pend_upper,busy got %b expected 01", {pend_upper, busy});
        end
        check_entry("upper_entry", sf, sd);
        checks++;
        if (!(sf && !sd && water_level >= 50)) begin
            errors++;
            $display("FAIL fill_to_high: fill=%0b drain=%0b level=%0d expected fill only and level>=50", sf, sd, water_level);
        end
        pulse(0, 0, 1, 0);
        repeat (3) cyc();
        checks++;
        if ({occupied, upper_gate} !== 2'b01) begin
            errors++;
            $display("FAIL boat_in_ignored_in_open: occupied,upper_gate got %b expected 01", {occupied, upper_gate});
        end
        pulse(0, 0, 1, 0);
        checks++;
        if ({occupied, upper_gate} !== 2'b10) begin
            errors++;
            $display("FAIL boat_in_accept: occupied,upper_gate got %b expected 10", {occupied, upper_gate});
        end
        wait_gate("exit_gate", side, sf, sd);
        checks++;
        if (!(side == 0 && sd && !sf && water_level <= 10)) begin
            errors++;
            $display("FAIL drain_to_low: side=%0b fill=%0b drain=%0b level=%0d expected lower, drain only, level<=10", side, sf, sd, water_level);
        end
        pulse(0, 0, 0, 1);
        repeat (3) cyc();
        checks++;
        if ({occupied, lower_gate} !== 2'b11) begin
            errors++;
            $display("FAIL boat_out_ignored_in_open: occupied,lower_gate got %b expected 11", {occupied, lower_gate});
        end
        pulse(0, 0, 0, 1);
        checks++;
        if ({occupied, lower_gate, busy} !== 3'b001) begin
            errors++;
            $display("FAIL boat_out_accept: occupied,lower_gate,busy got %b expected 001", {occupied, lower_gate, busy});
        end
        repeat (3) cyc();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL close_out_len_a: busy got %b expected 1", busy);
        end
        cyc();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL close_out_len_b: busy got %b expected 0", busy);
        end
        wait_idle("upper_idle", n);
    endtask

    task automatic run_transit(input string name);
        bit sf, sd, side;
        int n;
        check_entry(name, sf, sd);
        repeat (4) cyc();
        pulse(0, 0, 1, 0);
        wait_gate(name, side, sf, sd);
        repeat (4) cyc();
        pulse(0, 0, 0, 1);
        wait_idle(name, n);
    endtask

    task automatic test_arbitration();
        do_reset();
        water_level = 10;
        pulse(1, 1, 0, 0);
        exp_q.push_back(1);
        exp_q.push_back(0);
        checks++;
        if ({pend_upper, pend_lower} !== 2'b11) begin
            errors++;
            $display("FAIL tie_latch: pend got %b expected 11", {pend_upper, pend_lower});
        end
        cyc();
        checks++;
        if ({pend_upper, pend_lower, busy} !== 3'b011) begin
            errors++;
            $display("FAIL tie_grant: pend_upper,pend_lower,busy got %b expected 011", {pend_upper, pend_lower, busy});
        end
        run_transit("tie_first");
        checks++;
        if (pend_lower !== 1'b1) begin
            errors++;
            $display("FAIL tie_lower_kept: pend_lower got %b expected 1", pend_lower);
        end
        run_transit("tie_second");
        checks++;
        if ({pend_upper, pend_lower, busy} !== 3'b000) begin
            errors++;
            $display("FAIL tie_done: pend_upper,pend_lower,busy got %b expected 000", {pend_upper, pend_lower, busy});
        end
    endtask

    task automatic test_timeout();
        bit sf, sd, valve, occ;
        int n, m;
        do_reset();
        water_level = 50;
        pulse(1, 0, 0, 0);
        exp_q.push_back(1);
        check_entry("timeout_entry", sf, sd);
        n = 0;
        valve = sf | sd;
        occ = 0;
        while (upper_gate && n < 200) begin
            valve |= fill | drain;
            occ |= occupied;
            cyc();
            n++;
        end
        checks++;
        if (n != 67) begin
            errors++;
            $display("FAIL timeout_gate_len: gate open %0d cycles expected 67", n);
        end
        wait_idle("timeout_idle", m);
        checks++;
        if (m != 4) begin
            errors++;
            $display("FAIL timeout_close_len: close took %0d cycles expected 4", m);
        end
        checks++;
        if (valve || occ || fill || drain) begin
            errors++;
            $display("FAIL timeout_no_transfer: valve=%0b occupied=%0b expected 0 0", valve | fill | drain, occ);
        end
    endtask

    task automatic test_lower_no_valve();
        do_reset();
        water_level = 5;
        pulse(0, 1, 0, 0);
        cyc();
        checks++;
        if ({lower_gate, busy} !== 2'b01) begin
            errors++;
            $display("FAIL lower_adjust: lower_gate,busy got %b expected 01", {lower_gate, busy});
        end
        cyc();
        checks++;
        if ({upper_gate, lower_gate, fill, drain} !== 4'b0100) begin
            errors++;
            $display("FAIL lower_direct_open: gates,fill,drain got %b expected 0100", {upper_gate, lower_gate, fill, drain});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        water_level = 50;
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        checks++;
        if ({pend_upper, busy} !== 2'b11) begin
            errors++;
            $display("FAIL repend_on_grant: pend_upper,busy got %b expected 11", {pend_upper, busy});
        end
    endtask

    task automatic test_reset_mid();
        bit sf, sd;
        int n = 0;
        do_reset();
        water_level = 60;
        pulse(1, 0, 0, 0);
        exp_q.push_back(1);
        check_entry("mid_entry", sf, sd);
        repeat (4) cyc();
        pulse(0, 0, 1, 0);
        while (!drain && n < 50) begin
            cyc();
            n++;
        end
        pulse(0, 1, 0, 0);
        checks++;
        if ({drain, pend_lower} !== 2'b11) begin
            errors++;
            $display("FAIL mid_drain: drain,pend_lower got %b expected 11", {drain, pend_lower});
        end
        #2 reset = 0;
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL mid_async_reset: got %b expected 00000000", outs);
        end
        cyc();
        reset = 1;
        cyc();
        cyc();
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL mid_after_release: got %b expected 00000000", outs);
        end
    endtask

    task automatic test_random();
        do_reset();
        water_level = 10;
        for (int i = 0; i < 10000; i++) begin
            req_upper = $urandom_range(0, 19) == 0;
            req_lower = $urandom_range(0, 19) == 0;
            boat_in   = $urandom_range(0, 9) == 0;
            boat_out  = $urandom_range(0, 9) == 0;
            cyc();
            checks += 4;
            if (upper_gate && lower_gate) begin
                errors++;
                $display("FAIL inv_gates cycle %0d: both gates 1 expected at most one", i);
            end
            if (fill && drain) begin
                errors++;
                $display("FAIL inv_valves cycle %0d: fill and drain 1 expected at most one", i);
            end
            if ((upper_gate || lower_gate) && (fill || drain)) begin
                errors++;
                $display("FAIL inv_gate_valve cycle %0d: gate=%0b valve=%0b expected not both", i, upper_gate | lower_gate, fill | drain);
            end
            if ((upper_gate && water_level < 50) || (lower_gate && water_level > 10)) begin
                errors++;
                $display("FAIL inv_level cycle %0d: upper=%0b lower=%0b level=%0d expected matching level", i, upper_gate, lower_gate, water_level);
            end
        end
        {req_upper, req_lower, boat_in, boat_out} = '0;
    endtask

    initial begin
        test_reset();
        test_upper_transit();
        test_arbitration();
        test_timeout();
        test_lower_no_valve();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
